phasediff_seq: RTL and testbench

// - Snapshots N_CH channel phases from the PSDI front end on one sample strobe.
// - Feeds adjacent channel pairs, one at a time, through the single shared

---
 rtl/phasediff_seq_if.sv | 28 ++
 rtl/phasediff_seq.sv | 172 +++++++++++++++++
 tb/tb_phasediff_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/phasediff_seq_if.sv
// Result stream from phasediff_seq to the wind-direction solver.
// Each beat carries one wrapped phase difference and the index of the
// adjacent channel pair it belongs to, under a valid/ready handshake.
// PAIR_W must equal the sequencer's pair-index width:
// clog2(NUM_PAIRS), with a minimum of 1.
interface phasediff_seq_if #(
  parameter int PW     = 19,
  parameter int PAIR_W = 2
);
  logic [PW-1:0]     out_diff;
  logic [PAIR_W-1:0] out_pair;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_diff,
    output out_pair,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_diff,
    input  out_pair,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/phasediff_seq.sv
// phasediff_seq: snapshots N_CH channel phases on a sample strobe.
// It then walks the adjacent channel pairs through one shared, registered
// wrapped-difference unit (phasediff, one-cycle latency) and presents each
// result on the res stream, tagged with its pair index.
//
// Phases are signed Q9.10 degrees. This block does no arithmetic: pd_diff
// is passed through unmodified.
//
// Optional feature, enabled by defining PHDIFF_SEQ_OVERRUN_EN:
//   - overrun: sticky flag.
//   - overrun_cnt: 8-bit count that saturates at 255.
//   Both record sample strobes that arrive while a frame is in progress.
//   Only reset clears them.
module phasediff_seq #(
  parameter int N_CH = 4,   // channels, 2..16
  parameter int RING = 1,   // 1: include the closing pair N_CH-1 -> 0
  parameter int PW   = 19   // phase word width, must match phasediff
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_CH*PW-1:0] phase_in,
  input  logic               sample_valid,
  output logic [PW-1:0]      pd_phase1,
  output logic [PW-1:0]      pd_phase2,
  input  logic [PW-1:0]      pd_diff,
  phasediff_seq_if.master    res,
  output logic               busy,
  output logic               frame_done
`ifdef PHDIFF_SEQ_OVERRUN_EN
  ,
  output logic               overrun,
  output logic [7:0]         overrun_cnt
`endif
);

  localparam int NUM_PAIRS = (RING != 0) ? N_CH : N_CH - 1;
  localparam int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CH_W      = $clog2(N_CH);

  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [CH_W-1:0] LAST_PAIR = CH_W'(NUM_PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   snap [N_CH];
  logic [CH_W-1:0] pair;         // index k of the pair in flight
  logic [CH_W-1:0] nxt_a, nxt_b; // channels feeding pair k+1

  // Control strobes decoded from the FSM
  logic load_frame;  // accept a new snapshot and launch pair 0
  logic capture;     // take the phasediff result into the output register
  logic advance;     // handshake done, launch the next pair
  logic finish;      // handshake done on the last pair

  assign busy = (state != IDLE);

  // Channel indices of the next pair; the second one wraps to channel 0
  always_comb begin
    nxt_a = pair + CH_W'(1);
    nxt_b = (nxt_a == LAST_CH) ? '0 : nxt_a + CH_W'(1);
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is assigned with <= so that every flop samples
    // pre-edge values, whatever order the processes happen to run in.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and control-strobe decode
  always_comb begin
    // NOTE: every output gets a default before the case statement.
    // A path that forgets an assignment would otherwise infer a latch.
    state_next = state;
    load_frame = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          load_frame = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        // pd_phase1/2 stay put for this cycle; phasediff registers them on exit
        state_next = CAPTURE;
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = PRESENT;
      end
      PRESENT: begin
        if (res.out_ready) begin
          if (pair == LAST_PAIR) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = DRIVE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot, phasediff operand, output stream and frame_done registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the snapshot array is cleared on reset on purpose.
      // These are a handful of flops, not a RAM, and the reset state must
      // not leak phases from a previous frame.
      for (int k = 0; k < N_CH; k++) snap[k] <= '0;
      pair          <= '0;
      pd_phase1     <= '0;
      pd_phase2     <= '0;
      res.out_diff  <= '0;
      res.out_pair  <= '0;
      res.out_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= finish;

      if (load_frame) begin
        for (int k = 0; k < N_CH; k++) snap[k] <= phase_in[k*PW +: PW];
        // Pair 0 is taken straight from the input so DRIVE can follow at once
        pd_phase1 <= phase_in[PW-1:0];
        pd_phase2 <= phase_in[2*PW-1:PW];
        pair      <= '0;
      end

      if (advance) begin
        pair      <= nxt_a;
        pd_phase1 <= snap[nxt_a];
        pd_phase2 <= snap[nxt_b];
      end

      if (finish) pair <= '0;

      if (capture) begin
        res.out_diff  <= pd_diff;
        res.out_pair  <= pair[PAIR_W-1:0];
        res.out_valid <= 1'b1;
      end else if (advance || finish) begin
        res.out_valid <= 1'b0;
      end
    end
  end

`ifdef PHDIFF_SEQ_OVERRUN_EN
  // Sticky record of sample strobes that arrive while a frame is in progress
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (sample_valid && busy) begin
      overrun <= 1'b1;
      if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phasediff_seq.sv
// Self-checking bench for phasediff_seq.
// Two instances are driven: dut_r (N_CH=4, RING=1) and dut_l (N_CH=4, RING=0).
// A behavioural phasediff unit sits behind each instance.
// The expected results come from the channel phases. Each pair is the
// difference of neighbouring channels, wrapped into +/-180 deg, and arrives
// on a fixed 3-cycle-per-pair schedule.
module tb_phasediff_seq;

  localparam int PW      = 19;
  localparam int HALF    = 184320;   // 180 deg, 0x2D000
  localparam int FULL    = 368640;   // 360 deg

  logic            clock = 1'b0;
  logic            reset_n;
  logic [4*PW-1:0] phase_in;
  logic            sv_r, sv_l, rdy, sel;
  logic [PW-1:0]   pd1_r, pd2_r, pdd_r, pd1_l, pd2_l, pdd_l;
  logic            busy_r, busy_l, fd_r, fd_l;
`ifdef PHDIFF_SEQ_OVERRUN_EN
  logic            ovr_r, ovr_l;
  logic [7:0]      ovc_r, ovc_l;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [PW-1:0] ch    [4];
  logic [PW-1:0] got_d [4];

  phasediff_seq_if #(.PW(PW), .PAIR_W(2)) if_r ();
  phasediff_seq_if #(.PW(PW), .PAIR_W(2)) if_l ();

  assign if_r.out_ready = rdy;
  assign if_l.out_ready = rdy;

  phasediff_seq #(.N_CH(4), .RING(1), .PW(PW)) dut_r (
    .clock(clock), .reset_n(reset_n), .phase_in(phase_in), .sample_valid(sv_r),
    .pd_phase1(pd1_r), .pd_phase2(pd2_r), .pd_diff(pdd_r), .res(if_r),
    .busy(busy_r), .frame_done(fd_r)
`ifdef PHDIFF_SEQ_OVERRUN_EN
    , .overrun(ovr_r), .overrun_cnt(ovc_r)
`endif
  );

  phasediff_seq #(.N_CH(4), .RING(0), .PW(PW)) dut_l (
    .clock(clock), .reset_n(reset_n), .phase_in(phase_in), .sample_valid(sv_l),
    .pd_phase1(pd1_l), .pd_phase2(pd2_l), .pd_diff(pdd_l), .res(if_l),
    .busy(busy_l), .frame_done(fd_l)
`ifdef PHDIFF_SEQ_OVERRUN_EN
    , .overrun(ovr_l), .overrun_cnt(ovc_l)
`endif
  );

  always #5 clock = ~clock;

  // Reference wrapped difference b - a, folded into [-180, +180] degrees
  function automatic logic [PW-1:0] ref_wrap(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int d;
    d = int'($signed(b)) - int'($signed(a));
    if (d > HALF)       d -= FULL;
    else if (d < -HALF) d += FULL;
    return d[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] rnd_phase();
    int v;
    v = int'($urandom_range(FULL)) - HALF;
    return v[PW-1:0];
  endfunction

  // Behavioural phasediff units: one register stage after the operands
  always @(posedge clock) begin
    pdd_r <= ref_wrap(pd1_r, pd2_r);
    pdd_l <= ref_wrap(pd1_l, pd2_l);
  end

  // Observation mux, selecting the instance under test
  logic          o_valid, o_busy, o_fd;
  logic [PW-1:0] o_diff, o_pd1, o_pd2;
  logic [1:0]    o_pair;
  assign o_valid = sel ? if_l.out_valid : if_r.out_valid;
  assign o_diff  = sel ? if_l.out_diff  : if_r.out_diff;
  assign o_pair  = sel ? if_l.out_pair  : if_r.out_pair;
  assign o_pd1   = sel ? pd1_l : pd1_r;
  assign o_pd2   = sel ? pd2_l : pd2_r;
  assign o_busy  = sel ? busy_l : busy_r;
  assign o_fd    = sel ? fd_l : fd_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drive_sv(input bit s, input bit v);
    sv_r = (s == 1'b0) && v;
    sv_l = (s == 1'b1) && v;
  endtask

  // One frame on instance s (0: ring, 1: linear).
  // Options:
  //   - stall: out_ready is held low for stall_len cycles while stall_pair
  //     is presented.
  //   - extra_sv: a second strobe with new phases is issued at t+4.
  //   - abort_pair: the task returns while that pair is presented, so the
  //     caller can apply reset.
  task automatic run_frame(input bit s, input int stall_pair, input int stall_len,
                           input bit extra_sv, input int abort_pair);
    int np, t, budget, stalled, nk;
    logic [PW-1:0] hold_d;
    np      = s ? 3 : 4;
    sel     = s;
    stalled = 0;
    phase_in = {ch[3], ch[2], ch[1], ch[0]};
    drive_sv(s, 1'b1);
    t = cyc;
    tick();
    drive_sv(s, 1'b0);
    for (int k = 0; k < np; k++) begin
      nk = (k + 1) % 4;
      budget = 0;
      while (o_valid !== 1'b1 && budget < 40) begin
        if (extra_sv && cyc == t + 4) begin
          drive_sv(s, 1'b1);
          for (int i = 0; i < 4; i++) phase_in[i*PW +: PW] = rnd_phase();
        end
        tick();
        drive_sv(s, 1'b0);
        budget++;
      end
      check($sformatf("valid_cycle p%0d", k), cyc, t + 3 + 3*k + stalled);
      check($sformatf("diff p%0d", k), o_diff, ref_wrap(ch[k], ch[nk]));
      check($sformatf("pair p%0d", k), o_pair, k);
      check($sformatf("pd_phase1 p%0d", k), o_pd1, ch[k]);
      check($sformatf("pd_phase2 p%0d", k), o_pd2, ch[nk]);
      check($sformatf("busy p%0d", k), o_busy, 1);
      got_d[k] = o_diff;
      if (k == abort_pair) return;
      if (k == stall_pair) begin
        rdy    = 1'b0;
        hold_d = o_diff;
        repeat (stall_len) begin
          tick();
          check($sformatf("stall valid p%0d", k), o_valid, 1);
          check($sformatf("stall diff p%0d", k), o_diff, hold_d);
          check($sformatf("stall pair p%0d", k), o_pair, k);
          check($sformatf("stall pd1 p%0d", k), o_pd1, ch[k]);
          check($sformatf("stall pd2 p%0d", k), o_pd2, ch[nk]);
        end
        rdy = 1'b1;
        stalled += stall_len;
      end
      tick();
      check($sformatf("valid drop p%0d", k), o_valid, 0);
    end
    check("frame_done cycle", cyc, t + 3*np + 1 + stalled);
    check("frame_done pulse", o_fd, 1);
    check("busy after frame", o_busy, 0);
    tick();
    check("frame_done single", o_fd, 0);
  endtask

  initial begin
    logic [PW-1:0] exp_t1 [4];
    reset_n  = 1'b1;
    sv_r     = 1'b0;
    sv_l     = 1'b0;
    rdy      = 1'b1;
    sel      = 1'b0;
    phase_in = '0;
    #2 reset_n = 1'b0;
    #1;
    // Reset state of both instances
    check("rst valid_r", if_r.out_valid, 0);
    check("rst diff_r", if_r.out_diff, 0);
    check("rst pair_r", if_r.out_pair, 0);
    check("rst pd1_r", pd1_r, 0);
    check("rst pd2_r", pd2_r, 0);
    check("rst busy_r", busy_r, 0);
    check("rst fd_r", fd_r, 0);
    check("rst valid_l", if_l.out_valid, 0);
    check("rst busy_l", busy_l, 0);
    check("rst fd_l", fd_l, 0);
`ifdef PHDIFF_SEQ_OVERRUN_EN
    check("rst overrun", ovr_r, 0);
    check("rst overrun_cnt", ovc_r, 0);
`endif
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    tick();
    tick();

    // T1: 0/10/30/60 deg, ready held high
    ch[0] = 19'h00000; ch[1] = 19'h02800; ch[2] = 19'h07800; ch[3] = 19'h0F000;
    run_frame(1'b0, -1, 0, 1'b0, -1);
    exp_t1[0] = 19'h02800; exp_t1[1] = 19'h05000; exp_t1[2] = 19'h07800; exp_t1[3] = 19'h71000;
    for (int k = 0; k < 4; k++) check($sformatf("T1 literal p%0d", k), got_d[k], exp_t1[k]);

    // T2: +170 -> -170 deg wraps to +20 deg
    ch[0] = 19'h2A800; ch[1] = 19'h55800; ch[2] = rnd_phase(); ch[3] = rnd_phase();
    run_frame(1'b0, -1, 0, 1'b0, -1);
    check("T2 wrapped p0", got_d[0], 19'h05000);

    // T3: back-pressure for 5 cycles on pair 1
    for (int i = 0; i < 4; i++) ch[i] = rnd_phase();
    run_frame(1'b0, 1, 5, 1'b0, -1);

    // T4: second strobe mid-frame is ignored
    for (int i = 0; i < 4; i++) ch[i] = rnd_phase();
    run_frame(1'b0, -1, 0, 1'b1, -1);
`ifdef PHDIFF_SEQ_OVERRUN_EN
    check("T4 overrun", ovr_r, 1);
    check("T4 overrun_cnt", ovc_r, 1);
`endif

    // T5: reset while pair 1 is presented, then a clean restart
    for (int i = 0; i < 4; i++) ch[i] = rnd_phase();
    run_frame(1'b0, -1, 0, 1'b0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("T5 valid", if_r.out_valid, 0);
    check("T5 diff", if_r.out_diff, 0);
    check("T5 pair", if_r.out_pair, 0);
    check("T5 pd1", pd1_r, 0);
    check("T5 pd2", pd2_r, 0);
    check("T5 busy", busy_r, 0);
    check("T5 frame_done", fd_r, 0);
`ifdef PHDIFF_SEQ_OVERRUN_EN
    check("T5 overrun", ovr_r, 0);
    check("T5 overrun_cnt", ovc_r, 0);
`endif
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("T5 no frame_done", fd_r, 0);
    end
    for (int i = 0; i < 4; i++) ch[i] = rnd_phase();
    run_frame(1'b0, -1, 0, 1'b0, -1);

    // T6: linear chain, three pairs only
    ch[0] = 19'h00000; ch[1] = 19'h02800; ch[2] = 19'h07800; ch[3] = 19'h0F000;
    run_frame(1'b1, -1, 0, 1'b0, -1);
    check("T6 busy ring idle", busy_r, 0);

    // Randomised frames on both instances with random back-pressure
    for (int f = 0; f < 10; f++) begin
      bit s;
      int sp, sl;
      for (int i = 0; i < 4; i++) ch[i] = rnd_phase();
      s  = 1'($urandom_range(1));
      sp = int'($urandom_range(3)) - 1;
      sl = int'($urandom_range(4));
      run_frame(s, sp, sl, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "time limit");
  end

endmodule
